// File: rtl/gate_bcd_counter_if.sv
// gate_bcd_counter_if: measured-signal inputs and live/latched BCD count outputs of the gated counter.
interface gate_bcd_counter_if;
    logic            sig_in_i;
    logic            gate_tick_i;
    logic [6:0][3:0] num_o;
    logic            latch_pulse_o;
    logic            ovf_o;
    logic            counting_o;
    modport master (output sig_in_i, gate_tick_i, input num_o, latch_pulse_o, ovf_o, counting_o);
    modport slave  (input sig_in_i, gate_tick_i, output num_o, latch_pulse_o, ovf_o, counting_o);
endinterface

// File: rtl/gate_bcd_counter.sv
// gate_bcd_counter: gated 7-digit BCD edge counter with end-of-window latch pulse.
// Define GATE_CNT_SAT_EN to saturate at 9999999 on overflow; otherwise the count wraps.
module gate_bcd_counter #(
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    gate_bcd_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, LATCH, CLEAR} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   latch_q;
    logic                   ovf_q;
    logic                   counting_q;
    logic [6:0][3:0]        num_q;
    logic [6:0][3:0]        inc_d;
    logic [6:0][3:0]        num_d;
    logic                   all_nine;
    logic                   rise_d;
    assign rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    // all_nine ends up set only when every digit is 9, i.e. the next edge overflows
    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < 7; i++) begin
            inc_d[i] = all_nine ? ((num_q[i] == 4'd9) ? 4'd0 : num_q[i] + 4'd1) : num_q[i];
            all_nine = all_nine & (num_q[i] == 4'd9);
        end
    end
`ifdef GATE_CNT_SAT_EN
    assign num_d = all_nine ? num_q : inc_d;
`else
    assign num_d = inc_d;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            num_q      <= '0;
            ovf_q      <= 1'b0;
            latch_q    <= 1'b0;
            counting_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            case (state_q)
                IDLE: if (bus.gate_tick_i) begin
                    state_q    <= COUNT;
                    counting_q <= 1'b1;
                end
                COUNT: begin
                    if (rise_d) begin
                        num_q <= num_d;
                        ovf_q <= ovf_q | all_nine;
                    end
                    if (bus.gate_tick_i) begin
                        state_q    <= LATCH;
                        latch_q    <= 1'b1;
                        counting_q <= 1'b0;
                    end
                end
                LATCH: begin
                    state_q <= CLEAR;
                    latch_q <= 1'b0;
                    num_q   <= '0;
                    ovf_q   <= 1'b0;
                end
                default: begin
                    state_q    <= COUNT;
                    counting_q <= 1'b1;
                end
            endcase
        end
    end
    assign bus.num_o         = num_q;
    assign bus.latch_pulse_o = latch_q;
    assign bus.ovf_o         = ovf_q;
    assign bus.counting_o    = counting_q;
endmodule

// File: tb/tb_gate_bcd_counter.sv
// tb_gate_bcd_counter: directed windows with expected latched counts queued and checked on latch_pulse.
module tb_gate_bcd_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    gate_bcd_counter_if bus();
    gate_bcd_counter #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic [27:0] num;
        logic        ovf;
    } exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;
`ifdef GATE_CNT_SAT_EN
    localparam logic [27:0] OVF_NUM = 28'h9999999;
`else
    localparam logic [27:0] OVF_NUM = 28'h0000000;
`endif
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulses(input int n);
        repeat (n) begin
            @(negedge clk) bus.sig_in_i = 1'b1;
            @(negedge clk) bus.sig_in_i = 1'b0;
        end
    endtask
    task automatic open_win();
        @(negedge clk) bus.gate_tick_i = 1'b1;
        @(negedge clk) bus.gate_tick_i = 1'b0;
    endtask
    task automatic close_win(input logic [27:0] n, input logic o);
        cyc(3);
        @(negedge clk);
        bus.gate_tick_i = 1'b1;
        sb.push_back({n, o});
        @(negedge clk) bus.gate_tick_i = 1'b0;
    endtask
    // monitor: latched value, then cleared digits one cycle later, then counting again
    always @(negedge clk) begin
        exp_t e;
        if (p2) chk("counting_after_clear", {31'd0, bus.counting_o}, 32'd1);
        p2 = p1;
        if (p1) begin
            chk("digits_in_clear", {4'd0, bus.num_o}, 32'd0);
            chk("ovf_in_clear", {31'd0, bus.ovf_o}, 32'd0);
            chk("counting_in_clear", {31'd0, bus.counting_o}, 32'd0);
            chk("latch_one_cycle", {31'd0, bus.latch_pulse_o}, 32'd0);
        end
        p1 = 1'b0;
        if (bus.latch_pulse_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_latch: got latch_pulse with digits %0h, expected no latch_pulse", bus.num_o);
            end else begin
                e = sb.pop_front();
                chk("latch_digits", {4'd0, bus.num_o}, {4'd0, e.num});
                chk("latch_ovf", {31'd0, bus.ovf_o}, {31'd0, e.ovf});
            end
            p1 = 1'b1;
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1);
    end
    initial begin
        bus.sig_in_i    = 1'b0;
        bus.gate_tick_i = 1'b0;
        cyc(5);
        chk("rst_digits", {4'd0, bus.num_o}, 32'd0);
        chk("rst_counting", {31'd0, bus.counting_o}, 32'd0);
        chk("rst_latch", {31'd0, bus.latch_pulse_o}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf_o}, 32'd0);
        rst = 1'b1;
        pulses(3);
        cyc(3);
        chk("idle_digits", {4'd0, bus.num_o}, 32'd0);
        chk("idle_counting", {31'd0, bus.counting_o}, 32'd0);
        open_win();
        chk("count_after_tick", {31'd0, bus.counting_o}, 32'd1);
        pulses(1234);
        close_win(28'h0001234, 1'b0);
        cyc(2);
        // edge detected in the same cycle as the closing tick
        pulses(9);
        cyc(2);
        @(negedge clk) bus.sig_in_i = 1'b1;
        @(negedge clk) bus.sig_in_i = 1'b0;
        @(negedge clk);
        bus.gate_tick_i = 1'b1;
        sb.push_back({28'h0000010, 1'b0});
        @(negedge clk) bus.gate_tick_i = 1'b0;
        cyc(2);
        // edge detected during LATCH
        pulses(5);
        cyc(3);
        @(negedge clk) bus.sig_in_i = 1'b1;
        @(negedge clk);
        bus.sig_in_i    = 1'b0;
        bus.gate_tick_i = 1'b1;
        sb.push_back({28'h0000005, 1'b0});
        @(negedge clk) bus.gate_tick_i = 1'b0;
        cyc(2);
        // edge detected during CLEAR, plus a tick during CLEAR
        pulses(7);
        cyc(3);
        @(negedge clk);
        bus.sig_in_i    = 1'b1;
        bus.gate_tick_i = 1'b1;
        sb.push_back({28'h0000007, 1'b0});
        @(negedge clk);
        bus.sig_in_i    = 1'b0;
        bus.gate_tick_i = 1'b0;
        @(negedge clk) bus.gate_tick_i = 1'b1;
        @(negedge clk) bus.gate_tick_i = 1'b0;
        pulses(3);
        close_win(28'h0000003, 1'b0);
        cyc(3);
        force dut.num_q = 28'h9999998;
        #1 release dut.num_q;
        pulses(1);
        cyc(3);
        chk("live_9999999", {4'd0, bus.num_o}, 32'h09999999);
        chk("live_ovf_before", {31'd0, bus.ovf_o}, 32'd0);
        pulses(1);
        cyc(3);
        chk("live_ovf_digits", {4'd0, bus.num_o}, {4'd0, OVF_NUM});
        chk("live_ovf_set", {31'd0, bus.ovf_o}, 32'd1);
        close_win(OVF_NUM, 1'b1);
        cyc(3);
        pulses(500);
        cyc(3);
        chk("live_500", {4'd0, bus.num_o}, 32'h500);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("abort_digits", {4'd0, bus.num_o}, 32'd0);
        chk("abort_counting", {31'd0, bus.counting_o}, 32'd0);
        chk("abort_latch", {31'd0, bus.latch_pulse_o}, 32'd0);
        cyc(2);
        rst = 1'b1;
        pulses(2);
        cyc(3);
        chk("post_rst_idle", {31'd0, bus.counting_o}, 32'd0);
        chk("post_rst_digits", {4'd0, bus.num_o}, 32'd0);
        open_win();
        pulses(4);
        close_win(28'h0000004, 1'b0);
        cyc(4);
        chk("pending_latches", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
